// File: rtl/ds18b20_seq.sv
// DS18B20 measurement sequencer: drives the 1-Wire bit engine through reset, Skip ROM,
// Convert T, conversion wait, reset, Skip ROM, Read Scratchpad and returns the raw temperature.
module ds18b20_seq #(
  parameter int unsigned CONV_CYCLES = 18750000,
  parameter int unsigned HS_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        seq_busy,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        no_device,
  output logic        hs_error,
  output logic        ow_reset,
  output logic        ow_write_byte,
  output logic        ow_read_byte,
  output logic [63:0] ow_in_byte,
  output logic [5:0]  ow_start_bit,
  output logic [5:0]  ow_end_bit,
  input  logic        ow_busy,
  input  logic        ow_presence,
  input  logic [63:0] ow_out_byte
);

  typedef enum logic [2:0] {
    StIdle, StIssue, StWaitHi, StWaitLo, StConv, StCheck, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic        seq_busy_q, seq_busy_d;
  logic [15:0] temp_q, temp_d;
  logic        temp_valid_q, temp_valid_d;
  logic        no_device_q, no_device_d;
  logic        hs_error_q, hs_error_d;
  logic        ow_reset_q, ow_reset_d;
  logic        ow_write_q, ow_write_d;
  logic        ow_read_q, ow_read_d;
  logic [63:0] in_byte_q, in_byte_d;
  logic [5:0]  start_bit_q, start_bit_d;
  logic [5:0]  end_bit_q, end_bit_d;

  // Only the two scratchpad temperature bytes are consumed.
  logic unused_out_hi;
  assign unused_out_hi = ^ow_out_byte[63:16];

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    seq_busy_d   = seq_busy_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    no_device_d  = no_device_q;
    hs_error_d   = hs_error_q;
    ow_reset_d   = 1'b0;
    ow_write_d   = 1'b0;
    ow_read_d    = 1'b0;
    in_byte_d    = in_byte_q;
    start_bit_d  = start_bit_q;
    end_bit_d    = end_bit_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          no_device_d = 1'b0;
          hs_error_d  = 1'b0;
          seq_busy_d  = 1'b1;
          step_d      = 3'd0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d       = '0;
        state_d     = StWaitHi;
        in_byte_d   = '0;
        start_bit_d = 6'd0;
        end_bit_d   = 6'd7;
        case (step_q)
          3'd0, 3'd4: begin
            ow_reset_d = 1'b1;
            end_bit_d  = 6'd0;
          end
          3'd1, 3'd5: begin
            ow_write_d = 1'b1;
            in_byte_d  = {56'h0, 8'hCC};
          end
          3'd2: begin
            ow_write_d = 1'b1;
            in_byte_d  = {56'h0, 8'h44};
          end
          3'd6: begin
            ow_write_d = 1'b1;
            in_byte_d  = {56'h0, 8'hBE};
          end
          3'd7: begin
            ow_read_d = 1'b1;
            end_bit_d = 6'd15;
          end
          default: begin
            // Step 3 is never issued; treat it as a broken sequence.
            seq_busy_d = 1'b0;
            state_d    = StIdle;
          end
        endcase
      end
      StWaitHi: begin
        if (ow_busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == HS_TIMEOUT - 1) begin
          hs_error_d = 1'b1;
          seq_busy_d = 1'b0;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitLo: begin
        if (!ow_busy) state_d = StCheck;
      end
      StCheck: begin
        case (step_q)
          3'd0, 3'd4: begin
            if (!ow_presence) begin
              no_device_d = 1'b1;
              seq_busy_d  = 1'b0;
              state_d     = StIdle;
            end else begin
              step_d  = step_q + 3'd1;
              state_d = StIssue;
            end
          end
          3'd2: begin
            step_d  = 3'd3;
            cnt_d   = '0;
            state_d = StConv;
          end
          3'd7: begin
            temp_d       = ow_out_byte[15:0];
            temp_valid_d = 1'b1;
            state_d      = StDone;
          end
          default: begin
            step_d  = step_q + 3'd1;
            state_d = StIssue;
          end
        endcase
      end
      StConv: begin
        if (cnt_q == CONV_CYCLES - 1) begin
          step_d  = 3'd4;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        seq_busy_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        seq_busy_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      step_q       <= '0;
      cnt_q        <= '0;
      seq_busy_q   <= 1'b0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      no_device_q  <= 1'b0;
      hs_error_q   <= 1'b0;
      ow_reset_q   <= 1'b0;
      ow_write_q   <= 1'b0;
      ow_read_q    <= 1'b0;
      in_byte_q    <= '0;
      start_bit_q  <= '0;
      end_bit_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      seq_busy_q   <= seq_busy_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      no_device_q  <= no_device_d;
      hs_error_q   <= hs_error_d;
      ow_reset_q   <= ow_reset_d;
      ow_write_q   <= ow_write_d;
      ow_read_q    <= ow_read_d;
      in_byte_q    <= in_byte_d;
      start_bit_q  <= start_bit_d;
      end_bit_q    <= end_bit_d;
    end
  end

  assign seq_busy      = seq_busy_q;
  assign temp          = temp_q;
  assign temp_valid    = temp_valid_q;
  assign no_device     = no_device_q;
  assign hs_error      = hs_error_q;
  assign ow_reset      = ow_reset_q;
  assign ow_write_byte = ow_write_q;
  assign ow_read_byte  = ow_read_q;
  assign ow_in_byte    = in_byte_q;
  assign ow_start_bit  = start_bit_q;
  assign ow_end_bit    = end_bit_q;

endmodule

// File: doc/ds18b20_seq.md
Name: ds18b20_seq

Overview:
- Transaction sequencer that sits directly upstream of the 1-Wire bit engine and drives its reset/write_byte/read_byte command interface.
- On a start pulse it runs the full DS18B20 temperature measurement sequence: reset/presence, Skip ROM, Convert T, conversion wait, reset, Skip ROM, Read Scratchpad (2 bytes).
- Returns the raw 16-bit signed temperature (1/16 °C per LSB) with a one-cycle valid strobe.

Parameters:
- CONV_CYCLES, 18750000, conversion wait in clk cycles (750 ms at 25 MHz); test benches override it with small values.
- HS_TIMEOUT, 16, max cycles to wait for engine busy to rise after a command pulse.

Ports:
- clk  in  1  system clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a measurement
- seq_busy  out  1  sequence in progress
- temp  out  16  last temperature, scratchpad {byte1,byte0}
- temp_valid  out  1  one-cycle strobe when temp updates
- no_device  out  1  sticky; last reset saw no presence
- hs_error  out  1  sticky; engine failed to acknowledge a command
- ow_reset  out  1  engine reset command pulse
- ow_write_byte  out  1  engine write command pulse
- ow_read_byte  out  1  engine read command pulse
- ow_in_byte  out  64  engine write data, LSB sent first
- ow_start_bit  out  6  engine first bit index
- ow_end_bit  out  6  engine last bit index
- ow_busy  in  1  engine busy
- ow_presence  in  1  engine presence result
- ow_out_byte  in  64  engine read data

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: every output 0; state IDLE; step 0.
- Asserting reset_n mid-operation aborts immediately. All command pulses drop. Nothing further is issued until the next start.
- States:
  - IDLE
  - ISSUE: one cycle; drives the command for the current step.
  - WAIT_HI: waits for ow_busy=1.
  - WAIT_LO: waits for ow_busy=0.
  - CONV
  - CHECK
  - DONE
- Step sequence, 0..7:
  - 0: reset.
  - 1: write 0xCC.
  - 2: write 0x44.
  - 3: conversion wait.
  - 4: reset.
  - 5: write 0xCC.
  - 6: write 0xBE.
  - 7: read 16 bits.
- IDLE:
  - start=1 clears no_device and hs_error, sets seq_busy, and goes to ISSUE with step 0.
  - start while seq_busy=1 is ignored.
- ISSUE:
  - Registered command output is high for exactly one cycle, asserted on the edge leaving ISSUE.
  - Writes: ow_in_byte = {56'h0, byte}, ow_start_bit = 0, ow_end_bit = 7.
  - Read: ow_start_bit = 0, ow_end_bit = 15.
  - ow_in_byte, ow_start_bit and ow_end_bit are loaded on that same edge and held stable until the next ISSUE.
- WAIT_HI:
  - ow_busy=1 goes to WAIT_LO.
  - If ow_busy has not risen within HS_TIMEOUT cycles: set hs_error, clear seq_busy, go to IDLE.
- WAIT_LO:
  - ow_busy=0 goes to CHECK; there is no timeout.
- CHECK, after a reset step (0 or 4):
  - ow_presence=0: set no_device, clear seq_busy, go to IDLE, no temp_valid, no further commands.
  - ow_presence=1: step+1, go to ISSUE.
- CHECK, after step 2: enter CONV with counter 0.
- CONV:
  - Counter increments each cycle.
  - At CONV_CYCLES-1: step 4, go to ISSUE.
  - ow_reset therefore rises on the (CONV_CYCLES+2)th edge after the edge that sampled ow_busy low.
- CHECK, after step 7:
  - temp <= ow_out_byte[15:0], temp_valid=1 for one cycle, go to DONE.
- DONE: clear seq_busy, go to IDLE.
- A start arriving in the same cycle as DONE is ignored.
- temp holds its value until the next successful read. It is not cleared by error runs.
- Only one ow_* command is ever high in any cycle.
- No command is issued while ow_busy=1.

Test Plan:
- Engine model with presence=1 and read data 0x0191; start → commands in order reset, W 0xCC, W 0x44, reset, W 0xCC, W 0xBE, R(0..15). Every write uses start/end 0/7. Then temp=0x0191, temp_valid high for exactly 1 cycle, seq_busy low afterwards.
- Same run with CONV_CYCLES=100 → ow_reset of step 4 rises exactly 102 edges after ow_busy is sampled low following the 0x44 write.
- Presence=0 → no_device=1 after the first reset; no write/read commands issued; temp unchanged and temp_valid never asserted. A following good run clears no_device.
- Engine never raises busy → hs_error=1 after 16 cycles, seq_busy=0; a subsequent start clears hs_error.
- reset_n pulsed low during CONV → all outputs 0 asynchronously; no further commands after release until start. A second start pulse mid-sequence has no effect on the command order.
- Read data 0xFF5E (-10.125 °C) → temp=0xFF5E, temp_valid pulse.
